upload_reader: RTL



---
 rtl/upload_reader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/upload_reader.sv
// Upload-side responder: answers host read strobes for one upload index by
// reading a byte from a registered-output RAM port and returning it with a wait handshake.
module upload_reader #(
  parameter int         ADDR_WIDTH = 14,
  parameter logic [7:0] UP_INDEX   = 8'd4
) (
  input  logic                  clk_24,
  input  logic                  reset,
  input  logic                  up_active,
  input  logic [7:0]            up_index,
  input  logic [16:0]           up_addr,
  input  logic                  up_rd,
  output logic [7:0]            up_din,
  output logic                  up_wait,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rd,
  input  logic [7:0]            ram_data_in,
  output logic [16:0]           bytes_sent,
  output logic                  overrun,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [7:0]            r_din;
  logic [7:0]            w_din_nx;
  logic                  r_wait;
  logic                  w_wait_nx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nx;
  logic                  r_ram_rd;
  logic                  w_ram_rd_nx;
  logic [16:0]           r_bytes;
  logic [16:0]           w_bytes_nx;
  logic                  r_overrun;
  logic                  w_overrun_nx;
  logic                  r_done;
  logic                  w_done_nx;
  logic                  r_sel;

  logic                  w_sel;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_in_range;

  function automatic logic [16:0] sat_inc(input logic [16:0] v);
    return (v == 17'h1FFFF) ? v : v + 17'd1;
  endfunction

  // An index change while active drops w_sel, so it looks exactly like a falling edge.
  assign w_sel      = up_active && (up_index == UP_INDEX);
  assign w_rise     = w_sel && !r_sel;
  assign w_fall     = !w_sel && r_sel;
  assign w_in_range = ((up_addr >> ADDR_WIDTH) == 17'd0);

  // Next-state and next-output decode
  always_comb begin
    w_state_nx   = r_state;
    w_din_nx     = r_din;
    w_wait_nx    = r_wait;
    w_addr_nx    = r_addr;
    w_ram_rd_nx  = r_ram_rd;
    w_bytes_nx   = w_rise ? 17'd0 : r_bytes;
    w_overrun_nx = w_rise ? 1'b0 : r_overrun;
    w_done_nx    = w_fall;

    if (w_fall) begin
      w_state_nx  = ST_IDLE;
      w_wait_nx   = 1'b0;
      w_ram_rd_nx = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel && up_rd) begin
            if (w_in_range) begin
              w_addr_nx   = up_addr[ADDR_WIDTH-1:0];
              w_ram_rd_nx = 1'b1;
              w_wait_nx   = 1'b1;
              w_state_nx  = ST_READ;
            end else begin
              w_din_nx   = 8'hFF;
              w_bytes_nx = sat_inc(w_bytes_nx);
              w_state_nx = ST_IDLE;
            end
          end else begin
            w_state_nx = ST_IDLE;
          end
        end
        ST_READ: begin
          w_ram_rd_nx = 1'b0;
          w_state_nx  = ST_CAPTURE;
          if (w_sel && up_rd) begin
            w_overrun_nx = 1'b1;
          end else begin
            w_overrun_nx = w_overrun_nx;
          end
        end
        ST_CAPTURE: begin
          w_din_nx   = ram_data_in;
          w_wait_nx  = 1'b0;
          w_bytes_nx = sat_inc(w_bytes_nx);
          w_state_nx = ST_IDLE;
          if (w_sel && up_rd) begin
            w_overrun_nx = 1'b1;
          end else begin
            w_overrun_nx = w_overrun_nx;
          end
        end
        default: begin
          w_state_nx  = ST_IDLE;
          w_wait_nx   = 1'b0;
          w_ram_rd_nx = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_24) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_din     <= 8'h00;
      r_wait    <= 1'b0;
      r_addr    <= '0;
      r_ram_rd  <= 1'b0;
      r_bytes   <= 17'd0;
      r_overrun <= 1'b0;
      r_done    <= 1'b0;
      r_sel     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_din     <= w_din_nx;
      r_wait    <= w_wait_nx;
      r_addr    <= w_addr_nx;
      r_ram_rd  <= w_ram_rd_nx;
      r_bytes   <= w_bytes_nx;
      r_overrun <= w_overrun_nx;
      r_done    <= w_done_nx;
      r_sel     <= w_sel;
    end
  end

  assign up_din     = r_din;
  assign up_wait    = r_wait;
  assign ram_addr   = r_addr;
  assign ram_rd     = r_ram_rd;
  assign bytes_sent = r_bytes;
  assign overrun    = r_overrun;
  assign done       = r_done;

endmodule
